// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Purpose : Bundles the probe-bus load handshake, the CPU-side RAM bus and
//           the RAM write port that the program loader sits between.
// Signals :
//   load_start   1-cycle pulse that begins a new load session
//   load_valid   load_data / load_last are valid
//   load_data    image word
//   load_last    marks the final word of the image
//   load_ready   loader accepts a word this cycle
//   cpu_address  core address bus
//   cpu_wdata    core write data
//   cpu_we       core write enable
//   ram_address  RAM address
//   ram_wdata    RAM write data
//   ram_we       RAM write enable
// Modports: master = probe bus + core side (drives load_* and cpu_*),
//           slave  = the loader itself.
// ---------------------------------------------------------------------------
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;

  modport master (
    output load_start, load_valid, load_data, load_last,
    output cpu_address, cpu_wdata, cpu_we,
    input  load_ready,
    input  ram_address, ram_wdata, ram_we
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  cpu_address, cpu_wdata, cpu_we,
    output load_ready,
    output ram_address, ram_wdata, ram_we
  );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Purpose : Streams a program image from the probe bus into RAM at
//           consecutive addresses while holding the CPU in reset, then hands
//           the RAM port back to the core.
// Ports   :
//   clk           system clock
//   rst           asynchronous, active-high reset
//   bus           program_loader_if.slave (load handshake, cpu bus, ram port)
//   cpu_rst_out   reset to the core, high while loading and during the hold
//   busy          high in LOAD or HOLD
//   loaded_count  words written this session (0 .. 2**ADDR_WIDTH)
//   overflow_err  sticky: a word arrived after RAM was full
//   checksum      running sum of written words (0 unless enabled)
// Configuration:
//   LOADER_CHECKSUM_EN  when defined, checksum is the modulo-2**DATA_WIDTH
//                       sum of every word written this session; otherwise it
//                       is tied to zero.
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  program_loader_if.slave       bus,
  output logic                  cpu_rst_out,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   loaded_count,
  output logic                  overflow_err,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                state;
  state_t                state_next;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  wr_pending;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  accept;
  logic                  full;
  logic                  start;

  // loaded_count doubles as the write pointer. A word accepted while the
  // previous one is still in flight must account for that pending write,
  // both for the fullness test and for the address it will land on.
  assign start  = (state == IDLE) && bus.load_start;
  assign accept = (state == LOAD) && bus.load_valid;
  assign full   = (loaded_count + {{ADDR_WIDTH{1'b0}}, wr_pending}) == CAPACITY;

  // Next-state logic and output muxing. In IDLE the core owns the RAM port
  // combinationally; otherwise the registered loader write is presented.
  always_comb begin
    state_next      = state;
    bus.load_ready  = 1'b0;
    busy            = 1'b0;
    bus.ram_address = wr_addr;
    bus.ram_wdata   = wr_data;
    bus.ram_we      = wr_pending;
    case (state)
      IDLE: begin
        bus.ram_address = bus.cpu_address;
        bus.ram_wdata   = bus.cpu_wdata;
        bus.ram_we      = bus.cpu_we & ~rst;
        if (bus.load_start) state_next = LOAD;
      end
      LOAD: begin
        bus.load_ready = 1'b1;
        busy           = 1'b1;
        if (accept && bus.load_last) state_next = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == HOLD_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, write pipeline and session counters. cpu_rst_out is
  // registered from the next state so it drops together with the return
  // to IDLE and rises together with the entry to LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      wr_pending   <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      loaded_count <= '0;
      overflow_err <= 1'b0;
      cpu_rst_out  <= 1'b1;
    end else begin
      state       <= state_next;
      cpu_rst_out <= (state_next != IDLE);
      hold_cnt    <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      wr_pending  <= accept && !full;
      if (accept && !full) begin
        wr_addr <= loaded_count[ADDR_WIDTH-1:0] + ADDR_WIDTH'(wr_pending);
        wr_data <= bus.load_data;
      end
      if (start) begin
        loaded_count <= '0;
        overflow_err <= 1'b0;
      end else begin
        if (wr_pending) loaded_count <= loaded_count + 1'b1;
        if (accept && full) overflow_err <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Sum of the words actually written, updated in the write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (wr_pending) begin
      checksum <= checksum + wr_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Purpose : Directed-vector bench for program_loader. Expected RAM writes are
//           queued as stimulus is issued; a monitor pops and compares on
//           every ram_we cycle. Status outputs are checked against constants.
// ---------------------------------------------------------------------------
module tb_program_loader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rst_out;
  logic          busy;
  logic [AW:0]   loaded_count;
  logic          overflow_err;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  logic [DW-1:0] exp_sum = '0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cpu_rst_out  (cpu_rst_out),
    .busy         (busy),
    .loaded_count (loaded_count),
    .overflow_err (overflow_err),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses load_start; the optional valid word alongside must be ignored.
  task automatic startLoad(input logic with_valid);
    bus.load_start = 1'b1;
    bus.load_valid = with_valid;
    bus.load_data  = 8'h99;
    bus.load_last  = with_valid;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    exp_ptr = 0;
    exp_sum = '0;
  endtask

  // Offers one word for one cycle, queues its expected write, then idles.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic last,
                               input int gap);
    checkOutput("load_ready", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    if (exp_ptr < (1 << AW)) begin
      exp_q.push_back({AW'(exp_ptr), data});
      exp_sum = exp_sum + data;
      exp_ptr++;
    end
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, "_idle"}, busy, 0);
  endtask

  // Monitor: every RAM write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.ram_address, bus.ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("write_addr", bus.ram_address, mon_e[AW+DW-1:DW]);
        checkOutput("write_data", bus.ram_wdata, mon_e[DW-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst             = 1'b1;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    bus.cpu_address = 8'h40;
    bus.cpu_wdata   = 8'hA5;
    bus.cpu_we      = 1'b1;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cpu_rst_out", cpu_rst_out, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_load_ready", bus.load_ready, 0);
    checkOutput("rst_ram_we", bus.ram_we, 0);
    checkOutput("rst_checksum", checksum, 0);
    checkOutput("rst_loaded_count", loaded_count, 0);
    checkOutput("rst_overflow", overflow_err, 0);
    bus.cpu_we = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("cpu_rst_released", cpu_rst_out, 0);

    $display("[TB] idle passthrough");
    bus.cpu_we = 1'b1;
    exp_q.push_back({8'h40, 8'hA5});
    #1;
    checkOutput("pass_addr", bus.ram_address, 8'h40);
    checkOutput("pass_data", bus.ram_wdata, 8'hA5);
    checkOutput("pass_we", bus.ram_we, 1);
    tick();
    bus.cpu_we = 1'b0;

    $display("[TB] three-word load");
    startLoad(1'b1);
    bus.cpu_we = 1'b1;
    applyStimulus(8'h11, 1'b0, 0);
    applyStimulus(8'h22, 1'b0, 0);
    applyStimulus(8'h33, 1'b1, 0);
    bus.cpu_we = 1'b0;
    n = 0;
    while (cpu_rst_out && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rst_hold_cycles", n, 4);
    checkOutput("a_loaded_count", loaded_count, 3);
    checkOutput("a_overflow", overflow_err, 0);
    checkOutput("a_busy", busy, 0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("a_checksum", checksum, 8'h66);
`else
    checkOutput("a_checksum", checksum, 0);
`endif
    checkOutput("a_queue_empty", exp_q.size(), 0);

    $display("[TB] gapped load with ignored load_start");
    startLoad(1'b0);
    applyStimulus(8'hA0, 1'b0, 2);
    checkOutput("b_hold_we", bus.ram_we, 0);
    checkOutput("b_hold_addr", bus.ram_address, 8'h00);
    checkOutput("b_hold_data", bus.ram_wdata, 8'hA0);
    applyStimulus(8'hA1, 1'b0, 1);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    applyStimulus(8'hA2, 1'b0, 2);
    applyStimulus(8'hA3, 1'b1, 0);
    waitIdle("b");
    checkOutput("b_loaded_count", loaded_count, 4);
    checkOutput("b_overflow", overflow_err, 0);
    checkOutput("b_queue_empty", exp_q.size(), 0);

    $display("[TB] reset mid-load");
    startLoad(1'b0);
    applyStimulus(8'hB0, 1'b0, 1);
    applyStimulus(8'hB1, 1'b0, 1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hB2;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ram_we", bus.ram_we, 0);
    checkOutput("abort_cpu_rst_out", cpu_rst_out, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_load_ready", bus.load_ready, 0);
    tick();
    bus.load_valid = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("abort_released", cpu_rst_out, 0);
    checkOutput("abort_loaded_count", loaded_count, 0);
    bus.cpu_address = 8'h12;
    bus.cpu_wdata   = 8'h34;
    bus.cpu_we      = 1'b1;
    exp_q.push_back({8'h12, 8'h34});
    tick();
    bus.cpu_we = 1'b0;
    checkOutput("abort_queue_empty", exp_q.size(), 0);

    $display("[TB] overflow load of 257 words");
    startLoad(1'b0);
    for (int i = 0; i <= 256; i++) begin
      applyStimulus(DW'(i) ^ 8'h5A, (i == 256), 0);
    end
    waitIdle("c");
    checkOutput("c_overflow", overflow_err, 1);
    checkOutput("c_loaded_count", loaded_count, 9'h100);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("c_checksum", checksum, exp_sum);
`else
    checkOutput("c_checksum", checksum, 0);
`endif
    checkOutput("c_cpu_rst_out", cpu_rst_out, 0);
    repeat (2) tick();
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
